// File: rtl/peripheral_apb4_pkg.sv
// Shared types and sizing helpers for the APB4 RAM completer.
package peripheral_apb4_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int unsigned WCNT_W = 4;

  // Byte-offset bits inside one data word.
  function automatic int unsigned calc_bw(input int unsigned pdata_size);
    return $clog2(pdata_size / 8);
  endfunction

  // Word-index bits for the memory depth.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/peripheral_apb4_ram_core.sv
// Byte-enabled word memory with a registered (synchronous) read port.
module peripheral_apb4_ram_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned NB    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NB-1:0]     wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Read data holds between reads; rd_zero forces a zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: rtl/peripheral_apb4_slave_ram.sv
// APB4 completer backed by a byte-strobed RAM with programmable wait states.
// Define APB4_SLAVE_RAM_ERR_EN to flag out-of-range accesses with PSLVERR.
module peripheral_apb4_slave_ram
  import peripheral_apb4_pkg::*;
#(
  parameter int unsigned PADDR_SIZE  = 16,
  parameter int unsigned PDATA_SIZE  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    PRESETn,
  input  logic                    PCLK,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned NB        = PDATA_SIZE / 8;
  localparam int unsigned BW        = calc_bw(PDATA_SIZE);
  localparam int unsigned AW        = calc_aw(DEPTH);
  localparam int unsigned MEM_BYTES = DEPTH * NB;
  localparam int unsigned CMP_W     = PADDR_SIZE + 1;

  apb_state_e        state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]     word_idx;
  logic              wr_ok;
  logic              rd_zero;
  logic              wr_en;
  logic              rd_en;

  // Upper address bits beyond the memory alias unless range checking is on.
  assign word_idx = PADDR[AW+BW-1:BW];

`ifdef APB4_SLAVE_RAM_ERR_EN
  logic in_range;
  assign in_range = CMP_W'(PADDR) < CMP_W'(MEM_BYTES);
  assign wr_ok    = in_range;
  assign rd_zero  = !in_range;
  assign PSLVERR  = PREADY && !in_range;
`else
  logic unused_paddr;
  assign unused_paddr = ^PADDR;
  assign wr_ok        = 1'b1;
  assign rd_zero      = 1'b0;
  assign PSLVERR      = 1'b0;
`endif

  assign PREADY = (state_q == ACCESS) && (cnt_q == '0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait counter, and memory strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = WCNT_W'(WAIT_STATES);
          rd_en   = !PWRITE;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) cnt_d = cnt_q - WCNT_W'(1);
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE && PREADY) begin
          state_d = IDLE;
          wr_en   = PWRITE && wr_ok;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  peripheral_apb4_ram_core #(
    .DATA_W (PDATA_SIZE),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .wr_en   (wr_en),
    .wr_addr (word_idx),
    .wr_be   (PSTRB),
    .wr_data (PWDATA),
    .rd_en   (rd_en),
    .rd_zero (rd_zero),
    .rd_addr (word_idx),
    .rd_data (PRDATA)
  );

endmodule

// File: tb/tb_peripheral_apb4_slave_ram.sv
// Randomised APB4 bench for peripheral_apb4_slave_ram against a transaction-level memory model.
module tb_peripheral_apb4_slave_ram;

  localparam int DEPTH = 256;
  localparam int WS    = 3;
`ifdef APB4_SLAVE_RAM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic [15:0] PADDR;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  peripheral_apb4_slave_ram #(
    .PADDR_SIZE  (16),
    .PDATA_SIZE  (32),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .PRESETn (PRESETn),
    .PCLK    (clk),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSTRB   (PSTRB),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state and per-cycle expectations, written only by the driver.
  logic [31:0] mdl [DEPTH];
  logic        chk_en;
  logic        exp_ready;
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic        last_err;

  string       lit_name [128];
  logic [31:0] lit_act  [128];
  logic [31:0] lit_exp  [128];
  int          lit_n;

  // Counters, written only by the compare process.
  int checks;
  int failures;
  int lit_done;

  function automatic bit oor(input logic [15:0] a);
    return int'(a) >= DEPTH * 4;
  endfunction

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 4) % DEPTH;
  endfunction

  function automatic logic [31:0] model_rd(input logic [15:0] a);
    if (ERR && oor(a)) return 32'h0;
    return mdl[widx(a)];
  endfunction

  task automatic model_wr(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
    if (!(ERR && oor(a))) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[widx(a)][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  task automatic push_lit(input string n, input logic [31:0] a, input logic [31:0] e);
    if (lit_n < 128) begin
      lit_name[lit_n] = n;
      lit_act[lit_n]  = a;
      lit_exp[lit_n]  = e;
      lit_n++;
    end
  endtask

  task automatic idle_cycle();
    PSEL = 1'b0; PENABLE = 1'b0;
    exp_ready = 1'b0; exp_err = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #2;
    chk_en  = 1'b0;
    PRESETn = 1'b0;
    #1;
    push_lit("rst_pready", 32'(PREADY), 32'h0);
    push_lit("rst_pslverr", 32'(PSLVERR), 32'h0);
    push_lit("rst_prdata", PRDATA, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0;
    @(posedge clk); #1;
    PRESETn = 1'b1;
    chk_en  = 1'b1;
  endtask

  // One transfer; brk_k >= 0 aborts (or resets) in that access cycle.
  task automatic xfer(input bit wr, input logic [15:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int brk_k, input bit brk_rst);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PSTRB = s; PWDATA = d;
    exp_ready = 1'b0; exp_err = 1'b0;
    @(posedge clk); #1;
    if (!wr) exp_rdata = model_rd(a);
    PENABLE = 1'b1;
    for (int k = 0; k <= WS; k++) begin
      if (k == brk_k) begin
        if (brk_rst) begin
          do_reset();
        end else begin
          PSEL = 1'b0; PENABLE = 1'b0;
          exp_ready = 1'b0; exp_err = 1'b0;
          @(posedge clk); #1;
        end
        return;
      end
      exp_ready = (k == WS);
      exp_err   = exp_ready && ERR && oor(a);
      if (exp_ready) last_err = PSLVERR;
      @(posedge clk); #1;
    end
    if (wr) model_wr(a, s, d);
    exp_ready = 1'b0; exp_err = 1'b0;
  endtask

  task automatic wr_t(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
    xfer(1'b1, a, s, d, -1, 1'b0);
  endtask

  task automatic rd_t(input logic [15:0] a);
    xfer(1'b0, a, 4'h0, 32'h0, -1, 1'b0);
  endtask

  // Compare process: per-cycle model check plus queued literal checks.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checks++;
        if (PREADY !== exp_ready) begin
          failures++;
          $display("FAIL pready t=%0t act=%b exp=%b", $time, PREADY, exp_ready);
        end
        checks++;
        if (PSLVERR !== exp_err) begin
          failures++;
          $display("FAIL pslverr t=%0t act=%b exp=%b", $time, PSLVERR, exp_err);
        end
        checks++;
        if (PRDATA !== exp_rdata) begin
          failures++;
          $display("FAIL prdata t=%0t act=%h exp=%h", $time, PRDATA, exp_rdata);
        end
      end
      while (lit_done < lit_n) begin
        checks++;
        if (lit_act[lit_done] !== lit_exp[lit_done]) begin
          failures++;
          $display("FAIL %s act=%h exp=%h", lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
        end
        lit_done++;
      end
    end
  end

  initial begin
    int n;
    int ab;
    logic [15:0] a;
    chk_en = 1'b0; PRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0; PSTRB = '0; PWDATA = '0;
    exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0; last_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_lit("reset_pready", 32'(PREADY), 32'h0);
    push_lit("reset_pslverr", 32'(PSLVERR), 32'h0);
    push_lit("reset_prdata", PRDATA, 32'h0);
    PRESETn = 1'b1;
    chk_en  = 1'b1;

    // Fill memory so every later read has a defined model value.
    for (int i = 0; i < DEPTH; i++) wr_t(16'(i * 4), 4'hF, $urandom);

    // Basic write/read and wait-state latency probe.
    wr_t(16'h0010, 4'hF, 32'hDEADBEEF);
    idle_cycle();
    chk_en = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0013; PWRITE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    n = 0;
    while (PREADY !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    push_lit("wait_cycles", 32'(n), 32'd3);
    push_lit("rd_0010_err", 32'(PSLVERR), 32'h0);
    @(posedge clk); #1;
    push_lit("rd_0010_data", PRDATA, 32'hDEADBEEF);
    PSEL = 1'b0; PENABLE = 1'b0;
    exp_rdata = model_rd(16'h0010);
    chk_en = 1'b1;
    idle_cycle();

    // PENABLE without setup while idle must be ignored.
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 16'h0010; PWRITE = 1'b1; PSTRB = 4'hF; PWDATA = 32'h0BAD0BAD;
    exp_ready = 1'b0; exp_err = 1'b0;
    @(posedge clk); #1;
    idle_cycle();
    rd_t(16'h0010);
    push_lit("no_setup_ignored", PRDATA, 32'hDEADBEEF);

    // Byte strobes.
    wr_t(16'h0020, 4'hF, 32'h11223344);
    wr_t(16'h0020, 4'b0101, 32'hAABBCCDD);
    rd_t(16'h0020);
    push_lit("strobe_merge", PRDATA, 32'h11BB33DD);
    idle_cycle();

    // Out-of-range address 0x0400.
    wr_t(16'h0000, 4'hF, 32'hCAFEF00D);
    wr_t(16'h0400, 4'hF, 32'h12345678);
    push_lit("oor_wr_err", 32'(last_err), 32'(ERR));
    rd_t(16'h0000);
    push_lit("oor_mem0", PRDATA, ERR ? 32'hCAFEF00D : 32'h12345678);
    rd_t(16'h0400);
    push_lit("oor_rd_err", 32'(last_err), 32'(ERR));
    push_lit("oor_rd_data", PRDATA, ERR ? 32'h0 : 32'h12345678);
    idle_cycle();

    // Reset during ACCESS of a write discards it.
    wr_t(16'h0030, 4'hF, 32'h01020304);
    xfer(1'b1, 16'h0030, 4'hF, 32'hFFFFFFFF, 1, 1'b1);
    idle_cycle();
    rd_t(16'h0030);
    push_lit("rst_no_write", PRDATA, 32'h01020304);

    // Back-to-back write then read of the same word.
    wr_t(16'h0040, 4'hF, 32'h0000A5A5);
    rd_t(16'h0040);
    push_lit("b2b_read", PRDATA, 32'h0000A5A5);

    // Master abort drops the write.
    wr_t(16'h0044, 4'hF, 32'h11111111);
    xfer(1'b1, 16'h0044, 4'hF, 32'h22222222, 1, 1'b0);
    rd_t(16'h0044);
    push_lit("abort_no_write", PRDATA, 32'h11111111);
    idle_cycle();

    // Random traffic across in-range and out-of-range addresses.
    for (int t = 0; t < 300; t++) begin
      a  = 16'($urandom_range(0, 16'h07FF));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WS - 1)) : -1;
      xfer(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, ab, 1'b0);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    idle_cycle();
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
